ddr4_maint_read_sched: RTL

//  Sits between the SoftMC instruction pipeline and ddr4_adapter on the fabric clock.

---
 rtl/ddr4_maint_read_sched_pkg.sv | 38 +++
 rtl/ddr4_maint_read_sched_interval_timer.sv | 42 ++++
 rtl/ddr4_maint_read_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ddr4_maint_read_sched_pkg.sv
// rtl/ddr4_maint_read_sched_pkg.sv - widths, FSM states, maintenance target and idle-bundle helper
package ddr4_maint_read_sched_pkg;
  localparam int BG_WIDTH    = 2;
  localparam int BANK_WIDTH  = 2;
  localparam int COL_WIDTH   = 10;
  localparam int ROW_WIDTH   = 17;
  localparam int WDATA_WIDTH = 512;

  localparam int MAINT_PERIOD_DEF = 256;
  localparam int MAINT_LEAD_DEF   = 40;
  localparam int GAP_CYCLES_DEF   = 3;
  localparam int TRCD_CYCLES_DEF  = 5;
  localparam int RD_TIMEOUT_DEF   = 64;

  // Reserved target; user programs never address this bank.
  localparam int MAINT_BG   = 0;
  localparam int MAINT_BANK = 3;
  localparam int MAINT_ROW  = 0;
  localparam int MAINT_COL  = 0;

  typedef enum logic [2:0] {IDLE, RUN, GAP, ACT, TRCD, RD, WAIT} state_t;

  typedef struct packed {
    logic [3:0]               write, read, pre, act, refr, zq, nop, ap, half_bl, pall;
    logic [4*BG_WIDTH-1:0]    bg;
    logic [4*BANK_WIDTH-1:0]  bank;
    logic [4*COL_WIDTH-1:0]   col;
    logic [4*ROW_WIDTH-1:0]   row;
    logic [WDATA_WIDTH-1:0]   wdata;
  } bundle_t;

  function automatic bundle_t idle_bundle();
    bundle_t b;
    b = '0;
    b.nop = 4'hF;
    return b;
  endfunction
endpackage

// File: rtl/ddr4_maint_read_sched_interval_timer.sv
// rtl/ddr4_maint_read_sched_interval_timer.sv - maintenance period counter, due flag, sticky violation
module ddr4_maint_read_sched_interval_timer import ddr4_maint_read_sched_pkg::*; #(
  parameter int MAINT_PERIOD = MAINT_PERIOD_DEF,
  parameter int MAINT_LEAD   = MAINT_LEAD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  input  logic timeout,
  output logic maint_due,
  output logic violation
);
  localparam int CW = $clog2(MAINT_PERIOD + 1);
  localparam logic [CW-1:0] LIMIT  = CW'(MAINT_PERIOD);
  localparam logic [CW-1:0] THRESH = CW'(MAINT_PERIOD - MAINT_LEAD);

  logic [CW-1:0] period_ctr;
  logic [CW-1:0] ctr_nxt;

  always_comb begin
    ctr_nxt = period_ctr;
    if (!run || clear)
      ctr_nxt = '0;
    else if (period_ctr != LIMIT)
      ctr_nxt = period_ctr + CW'(1);
  end

  // maint_due is computed from the next count so it lines up with period_ctr.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_ctr <= '0;
      maint_due  <= 1'b0;
      violation  <= 1'b0;
    end else begin
      period_ctr <= ctr_nxt;
      maint_due  <= run && (ctr_nxt >= THRESH);
      if (timeout || (run && ctr_nxt == LIMIT))
        violation <= 1'b1;
    end
  end
endmodule

// File: rtl/ddr4_maint_read_sched.sv
// rtl/ddr4_maint_read_sched.sv - bundle forwarder with periodic PHY maintenance read; MAINT_STATS_EN builds maint_count
module ddr4_maint_read_sched import ddr4_maint_read_sched_pkg::*; #(
  parameter int MAINT_PERIOD = MAINT_PERIOD_DEF,
  parameter int MAINT_LEAD   = MAINT_LEAD_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int TRCD_CYCLES  = TRCD_CYCLES_DEF,
  parameter int RD_TIMEOUT   = RD_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_calib_complete,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_write, in_read, in_pre, in_act, in_ref,
  input  logic [3:0]               in_zq, in_nop, in_ap, in_half_bl, in_pall,
  input  logic [4*BG_WIDTH-1:0]    in_bg,
  input  logic [4*BANK_WIDTH-1:0]  in_bank,
  input  logic [4*COL_WIDTH-1:0]   in_col,
  input  logic [4*ROW_WIDTH-1:0]   in_row,
  input  logic [WDATA_WIDTH-1:0]   in_wdata,
  output logic [3:0]               ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref,
  output logic [3:0]               ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall,
  output logic [4*BG_WIDTH-1:0]    ddr_bg,
  output logic [4*BANK_WIDTH-1:0]  ddr_bank,
  output logic [4*COL_WIDTH-1:0]   ddr_col,
  output logic [4*ROW_WIDTH-1:0]   ddr_row,
  output logic [WDATA_WIDTH-1:0]   ddr_wdata,
  output logic                     ddr_maint_read,
  input  logic                     gt_data_ready,
  output logic                     maint_violation,
  output logic [15:0]              maint_count
);
  localparam int SW = 8;

  state_t        state, state_nxt;
  logic [SW-1:0] step_q, step_nxt;
  bundle_t       in_bundle, bundle_nxt, out_q;
  logic          maint_due, maint_read_nxt, timeout, done;

  assign in_bundle = '{write: in_write, read: in_read, pre: in_pre, act: in_act, refr: in_ref,
                       zq: in_zq, nop: in_nop, ap: in_ap, half_bl: in_half_bl, pall: in_pall,
                       bg: in_bg, bank: in_bank, col: in_col, row: in_row, wdata: in_wdata};

  assign in_ready = (state == RUN) && !maint_due;

  ddr4_maint_read_sched_interval_timer #(
    .MAINT_PERIOD(MAINT_PERIOD),
    .MAINT_LEAD  (MAINT_LEAD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .clear    (state == RD),
    .timeout  (timeout),
    .maint_due(maint_due),
    .violation(maint_violation)
  );

  always_comb begin
    state_nxt      = state;
    bundle_nxt     = idle_bundle();
    maint_read_nxt = 1'b0;
    timeout        = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: if (init_calib_complete) state_nxt = RUN;
      RUN: begin
        if (maint_due) state_nxt = GAP;
        else if (in_valid) bundle_nxt = in_bundle;
      end
      GAP: begin
        // The adapter registers ddr_maint_read, so it is raised one cycle before the read path.
        if (step_q == SW'(GAP_CYCLES - 1)) begin
          maint_read_nxt = 1'b1;
          state_nxt      = ACT;
        end
      end
      ACT: begin
        bundle_nxt.act                    = 4'b0001;
        bundle_nxt.nop                    = 4'b1110;
        bundle_nxt.bg[BG_WIDTH-1:0]       = BG_WIDTH'(MAINT_BG);
        bundle_nxt.bank[BANK_WIDTH-1:0]   = BANK_WIDTH'(MAINT_BANK);
        bundle_nxt.row[ROW_WIDTH-1:0]     = ROW_WIDTH'(MAINT_ROW);
        state_nxt                         = TRCD;
      end
      TRCD: if (step_q == SW'(TRCD_CYCLES - 2)) state_nxt = RD;
      RD: begin
        bundle_nxt.read                   = 4'b0001;
        bundle_nxt.ap                     = 4'b0001;
        bundle_nxt.nop                    = 4'b1110;
        bundle_nxt.bg[BG_WIDTH-1:0]       = BG_WIDTH'(MAINT_BG);
        bundle_nxt.bank[BANK_WIDTH-1:0]   = BANK_WIDTH'(MAINT_BANK);
        bundle_nxt.col[COL_WIDTH-1:0]     = COL_WIDTH'(MAINT_COL);
        state_nxt                         = WAIT;
      end
      WAIT: begin
        if (gt_data_ready) begin
          done      = 1'b1;
          state_nxt = RUN;
        end else if (step_q == SW'(RD_TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    step_nxt = (state_nxt != state) ? '0 : step_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      step_q         <= '0;
      out_q          <= idle_bundle();
      ddr_maint_read <= 1'b0;
    end else begin
      state          <= state_nxt;
      step_q         <= step_nxt;
      out_q          <= bundle_nxt;
      ddr_maint_read <= maint_read_nxt;
    end
  end

  assign ddr_write   = out_q.write;
  assign ddr_read    = out_q.read;
  assign ddr_pre     = out_q.pre;
  assign ddr_act     = out_q.act;
  assign ddr_ref     = out_q.refr;
  assign ddr_zq      = out_q.zq;
  assign ddr_nop     = out_q.nop;
  assign ddr_ap      = out_q.ap;
  assign ddr_half_bl = out_q.half_bl;
  assign ddr_pall    = out_q.pall;
  assign ddr_bg      = out_q.bg;
  assign ddr_bank    = out_q.bank;
  assign ddr_col     = out_q.col;
  assign ddr_row     = out_q.row;
  assign ddr_wdata   = out_q.wdata;

`ifdef MAINT_STATS_EN
  logic [15:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else if (done && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end
  assign maint_count = count_q;
`else
  logic unused_done;
  assign unused_done = done;
  assign maint_count = 16'h0;
`endif
endmodule
